// File: rtl/data_mem_axi_4_lite.sv
// -----------------------------------------------------------------------------
// data_mem_axi_4_lite
//
// AXI4-Lite responder that serves LSU loads and stores from an internal word
// array. The write and read channels each run their own FSM and can be busy
// at the same time. At most one transaction per channel is in flight.
//
// Write channel (W_IDLE -> W_COMMIT -> W_RESP):
//   AW and W handshakes are captured independently into holding registers,
//   in either order or in the same cycle. Once both are held, the write is
//   committed in a single W_COMMIT cycle, using the byte strobes. BVALID is
//   then held until BREADY.
// Read channel (R_IDLE -> [R_WAIT] -> R_DATA):
//   The address is latched on the AR handshake. After RD_LATENCY wait cycles
//   the word is sampled, and RVALID/RDATA/RRESP are held until RREADY.
// Out-of-range addresses return SLVERR. An out-of-range read returns zero
// data, and an out-of-range write leaves the array untouched.
//
// Ports:
//   clk, rst             clock; synchronous active-high reset
//   AXI_AW*              write address channel (AWPROT ignored)
//   AXI_W*               write data channel with byte strobes
//   AXI_B*               write response channel
//   AXI_AR*              read address channel (ARPROT ignored)
//   AXI_R*               read data channel
// -----------------------------------------------------------------------------
module data_mem_axi_4_lite #(
  parameter int unsigned           DATA_WIDTH = 64,
  parameter int unsigned           ADDR_WIDTH = 32,
  parameter int unsigned           DEPTH_LOG2 = 12,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 32'h8000_0000,
  parameter int unsigned           RD_LATENCY = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [ADDR_WIDTH-1:0]     AXI_AWADDR,
  input  logic [2:0]                AXI_AWPROT,
  input  logic                      AXI_AWVALID,
  output logic                      AXI_AWREADY,
  input  logic [DATA_WIDTH-1:0]     AXI_WDATA,
  input  logic [DATA_WIDTH/8-1:0]   AXI_WSTRB,
  input  logic                      AXI_WVALID,
  output logic                      AXI_WREADY,
  output logic [1:0]                AXI_BRESP,
  output logic                      AXI_BVALID,
  input  logic                      AXI_BREADY,
  input  logic [ADDR_WIDTH-1:0]     AXI_ARADDR,
  input  logic [2:0]                AXI_ARPROT,
  input  logic                      AXI_ARVALID,
  output logic                      AXI_ARREADY,
  output logic [DATA_WIDTH-1:0]     AXI_RDATA,
  output logic [1:0]                AXI_RRESP,
  output logic                      AXI_RVALID,
  input  logic                      AXI_RREADY
);

  localparam int unsigned STRB_W    = DATA_WIDTH / 8;
  localparam int unsigned BYTE_LOG2 = $clog2(STRB_W);
  localparam int unsigned SPAN_LOG2 = DEPTH_LOG2 + BYTE_LOG2;
  localparam int unsigned DEPTH     = 1 << DEPTH_LOG2;
  localparam logic [3:0]  RD_LAT    = 4'(RD_LATENCY);
  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam logic [1:0]  RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    W_IDLE   = 2'd0,
    W_COMMIT = 2'd1,
    W_RESP   = 2'd2
  } w_state_e;

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_WAIT = 2'd1,
    R_DATA = 2'd2
  } r_state_e;

  // An address is valid when it is at or above the base and its offset
  // fits in the array span. The offset is shifted right instead of compared
  // with a constant, so a span as wide as the address bus still works.
  function automatic logic addr_in_range(input logic [ADDR_WIDTH-1:0] addr);
    logic [ADDR_WIDTH-1:0] off;
    off = addr - BASE_ADDR;
    addr_in_range = (addr >= BASE_ADDR) && ((off >> SPAN_LOG2) == {ADDR_WIDTH{1'b0}});
  endfunction

  // Word index. The low byte-offset bits are dropped, so unaligned
  // addresses select their containing word and do not fault.
  function automatic logic [DEPTH_LOG2-1:0] word_index(input logic [ADDR_WIDTH-1:0] addr);
    logic [ADDR_WIDTH-1:0] off;
    off = addr - BASE_ADDR;
    word_index = DEPTH_LOG2'(off >> BYTE_LOG2);
  endfunction

  // Storage array. It is not reset.
  logic [DATA_WIDTH-1:0] mem_q [0:DEPTH-1];

  // ---------------------------------------------------------------------------
  // Write channel state
  // ---------------------------------------------------------------------------
  w_state_e              w_state_q, w_state_d;
  logic                  aw_held_q, aw_held_d;
  logic                  w_held_q,  w_held_d;
  logic [ADDR_WIDTH-1:0] aw_addr_q, aw_addr_d;
  logic [DATA_WIDTH-1:0] wdata_q,   wdata_d;
  logic [STRB_W-1:0]     wstrb_q,   wstrb_d;
  logic                  awready_q, awready_d;
  logic                  wready_q,  wready_d;
  logic                  bvalid_q,  bvalid_d;
  logic [1:0]            bresp_q,   bresp_d;
  logic                  wr_in_range;
  logic [DEPTH_LOG2-1:0] wr_index;

  assign wr_in_range = addr_in_range(aw_addr_q);
  assign wr_index    = word_index(aw_addr_q);

  // Write FSM next state, holding-register capture and next READY/VALID values
  always_comb begin
    w_state_d = w_state_q;
    aw_held_d = aw_held_q;
    w_held_d  = w_held_q;
    aw_addr_d = aw_addr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    bresp_d   = bresp_q;
    case (w_state_q)
      W_IDLE: begin
        if (AXI_AWVALID && awready_q) begin
          aw_held_d = 1'b1;
          aw_addr_d = AXI_AWADDR;
        end else begin
          aw_held_d = aw_held_q;
        end
        if (AXI_WVALID && wready_q) begin
          w_held_d = 1'b1;
          wdata_d  = AXI_WDATA;
          wstrb_d  = AXI_WSTRB;
        end else begin
          w_held_d = w_held_q;
        end
        // A same-cycle AW+W handshake goes straight to commit.
        if (aw_held_d && w_held_d) begin
          w_state_d = W_COMMIT;
        end else begin
          w_state_d = W_IDLE;
        end
      end
      W_COMMIT: begin
        w_state_d = W_RESP;
        if (wr_in_range) begin
          bresp_d = RESP_OKAY;
        end else begin
          bresp_d = RESP_SLVERR;
        end
      end
      W_RESP: begin
        if (bvalid_q && AXI_BREADY) begin
          w_state_d = W_IDLE;
          aw_held_d = 1'b0;
          w_held_d  = 1'b0;
        end else begin
          w_state_d = W_RESP;
        end
      end
      default: begin
        w_state_d = W_IDLE;
        aw_held_d = 1'b0;
        w_held_d  = 1'b0;
      end
    endcase
    // Handshake outputs are registered copies of the next state. This way
    // they never depend combinationally on the AXI inputs.
    awready_d = (w_state_d == W_IDLE) && !aw_held_d;
    wready_d  = (w_state_d == W_IDLE) && !w_held_d;
    bvalid_d  = (w_state_d == W_RESP);
  end

  // Write FSM registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      w_state_q <= W_IDLE;
      aw_held_q <= 1'b0;
      w_held_q  <= 1'b0;
      aw_addr_q <= {ADDR_WIDTH{1'b0}};
      wdata_q   <= {DATA_WIDTH{1'b0}};
      wstrb_q   <= {STRB_W{1'b0}};
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= 2'b00;
    end else begin
      w_state_q <= w_state_d;
      aw_held_q <= aw_held_d;
      w_held_q  <= w_held_d;
      aw_addr_q <= aw_addr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
    end
  end

  // Array byte-strobe write during the single commit cycle. Reset suppresses
  // it, so an aborted write never lands partially.
  always_ff @(posedge clk) begin
    if (!rst && (w_state_q == W_COMMIT) && wr_in_range) begin
      for (int i = 0; i < STRB_W; i++) begin
        if (wstrb_q[i]) begin
          mem_q[wr_index][i*8 +: 8] <= wdata_q[i*8 +: 8];
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Read channel state
  // ---------------------------------------------------------------------------
  r_state_e              r_state_q, r_state_d;
  logic [3:0]            r_cnt_q,   r_cnt_d;
  logic [ADDR_WIDTH-1:0] ar_addr_q, ar_addr_d;
  logic                  arready_q, arready_d;
  logic                  rvalid_q,  rvalid_d;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [1:0]            rresp_q;
  logic                  rd_sample;
  logic                  rd_in_range;
  logic [DEPTH_LOG2-1:0] rd_index;

  // The read decode uses the next-state address. With zero wait states,
  // the sample happens on the handshake edge itself.
  assign rd_in_range = addr_in_range(ar_addr_d);
  assign rd_index    = word_index(ar_addr_d);

  // Read FSM next state, wait counter and next READY/VALID values
  always_comb begin
    r_state_d = r_state_q;
    r_cnt_d   = r_cnt_q;
    ar_addr_d = ar_addr_q;
    case (r_state_q)
      R_IDLE: begin
        if (AXI_ARVALID && arready_q) begin
          ar_addr_d = AXI_ARADDR;
          r_cnt_d   = RD_LAT;
          if (RD_LAT == 4'd0) begin
            r_state_d = R_DATA;
          end else begin
            r_state_d = R_WAIT;
          end
        end else begin
          r_state_d = R_IDLE;
        end
      end
      R_WAIT: begin
        // R_WAIT lasts exactly RD_LATENCY cycles.
        r_cnt_d = r_cnt_q - 4'd1;
        if (r_cnt_q <= 4'd1) begin
          r_state_d = R_DATA;
        end else begin
          r_state_d = R_WAIT;
        end
      end
      R_DATA: begin
        if (rvalid_q && AXI_RREADY) begin
          r_state_d = R_IDLE;
        end else begin
          r_state_d = R_DATA;
        end
      end
      default: begin
        r_state_d = R_IDLE;
      end
    endcase
    arready_d = (r_state_d == R_IDLE);
    rvalid_d  = (r_state_d == R_DATA);
    rd_sample = (r_state_d == R_DATA) && (r_state_q != R_DATA);
  end

  // Read FSM registers. Data is sampled only when entering R_DATA. A
  // commit to the same word on that edge is not visible yet, so the read
  // returns the old data.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state_q <= R_IDLE;
      r_cnt_q   <= 4'd0;
      ar_addr_q <= {ADDR_WIDTH{1'b0}};
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= {DATA_WIDTH{1'b0}};
      rresp_q   <= 2'b00;
    end else begin
      r_state_q <= r_state_d;
      r_cnt_q   <= r_cnt_d;
      ar_addr_q <= ar_addr_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      if (rd_sample) begin
        if (rd_in_range) begin
          rdata_q <= mem_q[rd_index];
          rresp_q <= RESP_OKAY;
        end else begin
          rdata_q <= {DATA_WIDTH{1'b0}};
          rresp_q <= RESP_SLVERR;
        end
      end else begin
        rdata_q <= rdata_q;
        rresp_q <= rresp_q;
      end
    end
  end

  // The protection attributes have no effect on this memory.
  logic unused_prot;
  assign unused_prot = ^{AXI_AWPROT, AXI_ARPROT};

  assign AXI_AWREADY = awready_q;
  assign AXI_WREADY  = wready_q;
  assign AXI_BVALID  = bvalid_q;
  assign AXI_BRESP   = bresp_q;
  assign AXI_ARREADY = arready_q;
  assign AXI_RVALID  = rvalid_q;
  assign AXI_RDATA   = rdata_q;
  assign AXI_RRESP   = rresp_q;

endmodule

// File: tb/tb_data_mem_axi_4_lite.sv
// -----------------------------------------------------------------------------
// Bench for data_mem_axi_4_lite (default parameters: 64-bit data, 4096 words,
// base 0x8000_0000, one read wait state).
// -----------------------------------------------------------------------------
module tb_data_mem_axi_4_lite;

  localparam longint unsigned BASE = 64'h8000_0000;
  localparam longint unsigned SPAN = 64'd4096 * 64'd8;

  logic        clk;
  logic        rst;
  logic [31:0] AXI_AWADDR;
  logic [2:0]  AXI_AWPROT;
  logic        AXI_AWVALID;
  logic        AXI_AWREADY;
  logic [63:0] AXI_WDATA;
  logic [7:0]  AXI_WSTRB;
  logic        AXI_WVALID;
  logic        AXI_WREADY;
  logic [1:0]  AXI_BRESP;
  logic        AXI_BVALID;
  logic        AXI_BREADY;
  logic [31:0] AXI_ARADDR;
  logic [2:0]  AXI_ARPROT;
  logic        AXI_ARVALID;
  logic        AXI_ARREADY;
  logic [63:0] AXI_RDATA;
  logic [1:0]  AXI_RRESP;
  logic        AXI_RVALID;
  logic        AXI_RREADY;

  int total = 0;
  int bad   = 0;

  data_mem_axi_4_lite dut (
    .clk         (clk),
    .rst         (rst),
    .AXI_AWADDR  (AXI_AWADDR),
    .AXI_AWPROT  (AXI_AWPROT),
    .AXI_AWVALID (AXI_AWVALID),
    .AXI_AWREADY (AXI_AWREADY),
    .AXI_WDATA   (AXI_WDATA),
    .AXI_WSTRB   (AXI_WSTRB),
    .AXI_WVALID  (AXI_WVALID),
    .AXI_WREADY  (AXI_WREADY),
    .AXI_BRESP   (AXI_BRESP),
    .AXI_BVALID  (AXI_BVALID),
    .AXI_BREADY  (AXI_BREADY),
    .AXI_ARADDR  (AXI_ARADDR),
    .AXI_ARPROT  (AXI_ARPROT),
    .AXI_ARVALID (AXI_ARVALID),
    .AXI_ARREADY (AXI_ARREADY),
    .AXI_RDATA   (AXI_RDATA),
    .AXI_RRESP   (AXI_RRESP),
    .AXI_RVALID  (AXI_RVALID),
    .AXI_RREADY  (AXI_RREADY)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: window of 8 words at BASE, plus plain range arithmetic.
  logic [63:0] win [8];

  function automatic bit m_in_range(input logic [31:0] a);
    longint unsigned x;
    x = a;
    return (x >= BASE) && (x < BASE + SPAN);
  endfunction

  function automatic int m_index(input logic [31:0] a);
    longint unsigned x;
    x = a;
    return int'((x - BASE) / 64'd8);
  endfunction

  task automatic do_write(input logic [31:0] addr, input logic [63:0] data, input logic [7:0] strb,
                          input int bdelay, output logic [1:0] resp, output int lat);
    bit aw_done, w_done, aw_hs, w_hs;
    int guard;
    AXI_AWADDR = addr; AXI_AWVALID = 1'b1;
    AXI_WDATA = data; AXI_WSTRB = strb; AXI_WVALID = 1'b1;
    AXI_BREADY = 1'b0;
    aw_done = 1'b0; w_done = 1'b0; guard = 0;
    while (!(aw_done && w_done) && guard < 50) begin
      aw_hs = AXI_AWVALID && AXI_AWREADY;
      w_hs  = AXI_WVALID && AXI_WREADY;
      tick();
      if (aw_hs) begin AXI_AWVALID = 1'b0; aw_done = 1'b1; end
      if (w_hs)  begin AXI_WVALID = 1'b0;  w_done = 1'b1;  end
      guard++;
    end
    AXI_AWVALID = 1'b0; AXI_WVALID = 1'b0;
    chk("wr_handshake", 64'(aw_done && w_done), 64'd1);
    lat = 1;
    while (!AXI_BVALID && lat < 50) begin tick(); lat++; end
    chk("wr_bvalid_seen", 64'(AXI_BVALID), 64'd1);
    resp = AXI_BRESP;
    for (int k = 0; k < bdelay; k++) begin
      tick();
      chk("wr_bvalid_hold", 64'(AXI_BVALID), 64'd1);
      chk("wr_bresp_hold", 64'(AXI_BRESP), 64'(resp));
      chk("wr_awready_busy", 64'(AXI_AWREADY), 64'd0);
      chk("wr_wready_busy", 64'(AXI_WREADY), 64'd0);
    end
    AXI_BREADY = 1'b1;
    tick();
    AXI_BREADY = 1'b0;
    chk("wr_bvalid_drop", 64'(AXI_BVALID), 64'd0);
    chk("wr_awready_back", 64'(AXI_AWREADY), 64'd1);
  endtask

  task automatic do_read(input logic [31:0] addr, input int rdelay,
                         output logic [63:0] data, output logic [1:0] resp, output int lat);
    bit hs;
    int guard;
    AXI_ARADDR = addr; AXI_ARVALID = 1'b1; AXI_RREADY = 1'b0;
    hs = 1'b0; guard = 0;
    while (!hs && guard < 50) begin
      hs = AXI_ARVALID && AXI_ARREADY;
      tick();
      guard++;
    end
    AXI_ARVALID = 1'b0;
    chk("rd_handshake", 64'(hs), 64'd1);
    lat = 1;
    while (!AXI_RVALID && lat < 50) begin tick(); lat++; end
    chk("rd_rvalid_seen", 64'(AXI_RVALID), 64'd1);
    data = AXI_RDATA;
    resp = AXI_RRESP;
    for (int k = 0; k < rdelay; k++) begin
      tick();
      chk("rd_rvalid_hold", 64'(AXI_RVALID), 64'd1);
      chk("rd_rdata_hold", AXI_RDATA, data);
      chk("rd_rresp_hold", 64'(AXI_RRESP), 64'(resp));
      chk("rd_arready_busy", 64'(AXI_ARREADY), 64'd0);
    end
    AXI_RREADY = 1'b1;
    tick();
    AXI_RREADY = 1'b0;
    chk("rd_rvalid_drop", 64'(AXI_RVALID), 64'd0);
    chk("rd_arready_back", 64'(AXI_ARREADY), 64'd1);
  endtask

  typedef struct {
    bit          is_wr;
    logic [31:0] addr;
    logic [63:0] data;
    logic [7:0]  strb;
    logic [63:0] exp_data;
    logic [1:0]  exp_resp;
  } vec_t;

  initial begin
    vec_t        vecs[$];
    logic [63:0] rd;
    logic [1:0]  rsp;
    int          lat;
    bit          hs;
    int          g;

    vecs.push_back('{1'b1, 32'h8000_0010, 64'h1122_3344_5566_7788, 8'hFF, 64'h0, 2'b00});
    vecs.push_back('{1'b0, 32'h8000_0010, 64'h0, 8'h00, 64'h1122_3344_5566_7788, 2'b00});
    vecs.push_back('{1'b1, 32'h8000_0010, 64'hFFFF_FFFF_FFFF_FFFF, 8'h0F, 64'h0, 2'b00});
    vecs.push_back('{1'b0, 32'h8000_0010, 64'h0, 8'h00, 64'h1122_3344_FFFF_FFFF, 2'b00});
    vecs.push_back('{1'b1, 32'h8000_0000, 64'hA5A5_A5A5_5A5A_5A5A, 8'hFF, 64'h0, 2'b00});
    vecs.push_back('{1'b0, 32'h7FFF_FFF8, 64'h0, 8'h00, 64'h0, 2'b10});
    vecs.push_back('{1'b1, 32'h8000_8000, 64'hDEAD_BEEF_DEAD_BEEF, 8'hFF, 64'h0, 2'b10});
    vecs.push_back('{1'b0, 32'h8000_0000, 64'h0, 8'h00, 64'hA5A5_A5A5_5A5A_5A5A, 2'b00});
    vecs.push_back('{1'b1, 32'h8000_7FFF, 64'h0102_0304_0506_0708, 8'hFF, 64'h0, 2'b00});
    vecs.push_back('{1'b0, 32'h8000_7FF8, 64'h0, 8'h00, 64'h0102_0304_0506_0708, 2'b00});
    vecs.push_back('{1'b1, 32'h8000_0010, 64'h0, 8'h00, 64'h0, 2'b00});
    vecs.push_back('{1'b0, 32'h8000_0013, 64'h0, 8'h00, 64'h1122_3344_FFFF_FFFF, 2'b00});
    vecs.push_back('{1'b0, 32'h8000_8000, 64'h0, 8'h00, 64'h0, 2'b10});

    rst = 1'b1;
    AXI_AWADDR = 32'h0; AXI_AWPROT = 3'h0; AXI_AWVALID = 1'b0;
    AXI_WDATA = 64'h0; AXI_WSTRB = 8'h0; AXI_WVALID = 1'b0; AXI_BREADY = 1'b0;
    AXI_ARADDR = 32'h0; AXI_ARPROT = 3'h0; AXI_ARVALID = 1'b0; AXI_RREADY = 1'b0;

    // Reset state
    repeat (3) tick();
    chk("rst_awready", 64'(AXI_AWREADY), 64'd0);
    chk("rst_wready", 64'(AXI_WREADY), 64'd0);
    chk("rst_arready", 64'(AXI_ARREADY), 64'd0);
    chk("rst_bvalid", 64'(AXI_BVALID), 64'd0);
    chk("rst_rvalid", 64'(AXI_RVALID), 64'd0);
    chk("rst_bresp", 64'(AXI_BRESP), 64'd0);
    chk("rst_rresp", 64'(AXI_RRESP), 64'd0);
    chk("rst_rdata", AXI_RDATA, 64'd0);
    rst = 1'b0;
    tick();
    chk("idle_awready", 64'(AXI_AWREADY), 64'd1);
    chk("idle_wready", 64'(AXI_WREADY), 64'd1);
    chk("idle_arready", 64'(AXI_ARREADY), 64'd1);

    // Directed vector table
    foreach (vecs[i]) begin
      if (vecs[i].is_wr) begin
        do_write(vecs[i].addr, vecs[i].data, vecs[i].strb, 0, rsp, lat);
        chk("vec_bresp", 64'(rsp), 64'(vecs[i].exp_resp));
        chk("vec_wr_lat", 64'(lat), 64'd2);
      end else begin
        do_read(vecs[i].addr, 0, rd, rsp, lat);
        chk("vec_rresp", 64'(rsp), 64'(vecs[i].exp_resp));
        chk("vec_rdata", rd, vecs[i].exp_data);
        chk("vec_rd_lat", 64'(lat), 64'd2);
      end
    end

    // W arrives three cycles before AW
    AXI_WDATA = 64'hCAFE_F00D_1234_5678; AXI_WSTRB = 8'hFF; AXI_WVALID = 1'b1; AXI_BREADY = 1'b0;
    hs = 1'b0; g = 0;
    while (!hs && g < 20) begin hs = AXI_WVALID && AXI_WREADY; tick(); g++; end
    AXI_WVALID = 1'b0;
    chk("ord_w_hs", 64'(hs), 64'd1);
    for (int k = 0; k < 3; k++) begin
      chk("ord_wready_low", 64'(AXI_WREADY), 64'd0);
      chk("ord_awready_high", 64'(AXI_AWREADY), 64'd1);
      chk("ord_no_bvalid", 64'(AXI_BVALID), 64'd0);
      tick();
    end
    AXI_AWADDR = 32'h8000_0020; AXI_AWVALID = 1'b1;
    hs = 1'b0; g = 0;
    while (!hs && g < 20) begin hs = AXI_AWVALID && AXI_AWREADY; tick(); g++; end
    AXI_AWVALID = 1'b0;
    chk("ord_aw_hs", 64'(hs), 64'd1);
    lat = 1;
    while (!AXI_BVALID && lat < 50) begin tick(); lat++; end
    chk("ord_wr_lat", 64'(lat), 64'd2);
    chk("ord_bresp", 64'(AXI_BRESP), 64'd0);
    AXI_BREADY = 1'b1;
    tick();
    AXI_BREADY = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk("ord_single_bvalid", 64'(AXI_BVALID), 64'd0);
      tick();
    end
    do_read(32'h8000_0020, 0, rd, rsp, lat);
    chk("ord_readback", rd, 64'hCAFE_F00D_1234_5678);

    // Backpressure on both response channels
    do_write(32'h8000_0028, 64'h0BAD_F00D_0000_0001, 8'hFF, 5, rsp, lat);
    chk("bp_bresp", 64'(rsp), 64'd0);
    do_read(32'h8000_0028, 5, rd, rsp, lat);
    chk("bp_rdata", rd, 64'h0BAD_F00D_0000_0001);
    do_write(32'h8000_8008, 64'h1, 8'hFF, 5, rsp, lat);
    chk("bp_oor_bresp", 64'(rsp), 64'd2);

    // Reset while the read sits in its wait state
    AXI_ARADDR = 32'h8000_0010; AXI_ARVALID = 1'b1;
    chk("rstmid_arready", 64'(AXI_ARREADY), 64'd1);
    tick();
    AXI_ARVALID = 1'b0;
    chk("rstmid_wait_no_rvalid", 64'(AXI_RVALID), 64'd0);
    rst = 1'b1;
    tick();
    chk("rstmid_rvalid", 64'(AXI_RVALID), 64'd0);
    chk("rstmid_arready_low", 64'(AXI_ARREADY), 64'd0);
    rst = 1'b0;
    tick();
    chk("rstmid_arready_back", 64'(AXI_ARREADY), 64'd1);
    for (int k = 0; k < 4; k++) begin
      chk("rstmid_no_stale_rvalid", 64'(AXI_RVALID), 64'd0);
      tick();
    end

    // Randomized traffic against the window model
    for (int i = 0; i < 8; i++) begin
      win[i] = {$urandom, $urandom};
      do_write(32'h8000_0000 + 32'(i * 8), win[i], 8'hFF, 0, rsp, lat);
      chk("rnd_init_bresp", 64'(rsp), 64'd0);
    end
    for (int n = 0; n < 80; n++) begin
      logic [31:0] a;
      logic [63:0] d;
      logic [7:0]  s;
      logic [63:0] exp_d;
      int          sel;
      sel = int'($urandom_range(0, 99));
      if (sel < 80) begin
        a = 32'h8000_0000 + 32'($urandom_range(0, 7) * 8) + 32'($urandom_range(0, 7));
      end else if (sel < 90) begin
        a = 32'h8000_0000 - 32'(($urandom_range(0, 3) + 1) * 8);
      end else begin
        a = 32'h8000_8000 + 32'($urandom_range(0, 63));
      end
      if ($urandom_range(0, 1) == 1) begin
        d = {$urandom, $urandom};
        s = 8'($urandom);
        do_write(a, d, s, int'($urandom_range(0, 2)), rsp, lat);
        chk("rnd_bresp", 64'(rsp), m_in_range(a) ? 64'd0 : 64'd2);
        chk("rnd_wr_lat", 64'(lat), 64'd2);
        if (m_in_range(a)) begin
          for (int b = 0; b < 8; b++) begin
            if (s[b]) win[m_index(a)][b*8 +: 8] = d[b*8 +: 8];
          end
        end
      end else begin
        do_read(a, int'($urandom_range(0, 2)), rd, rsp, lat);
        exp_d = m_in_range(a) ? win[m_index(a)] : 64'd0;
        chk("rnd_rresp", 64'(rsp), m_in_range(a) ? 64'd0 : 64'd2);
        chk("rnd_rdata", rd, exp_d);
        chk("rnd_rd_lat", 64'(lat), 64'd2);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/data_mem_axi_4_lite.md
Name: data_mem_axi_4_lite

Overview:
AXI4-Lite responder (slave) data memory, the counterpart of the fetch-side AXI4-Lite initiators. It serves the LSU's read and write requests from an internal synchronous word array. Independent read and write channel FSMs are provided, with a programmable read wait-state count, byte-strobe writes, and SLVERR for out-of-range addresses.

Parameters:
DATA_WIDTH, 64, width of the RDATA and WDATA buses in bits (64 or 32); WSTRB is DATA_WIDTH/8.
ADDR_WIDTH, 32, width of AWADDR and ARADDR.
DEPTH_LOG2, 12, log2 of the number of DATA_WIDTH words in the array.
BASE_ADDR, 32'h8000_0000, byte address of word 0.
RD_LATENCY, 1, number of wait cycles (0..15) from the AR handshake to RVALID.

Ports:
clk  in  1  clock; all logic is on the rising edge.
rst  in  1  reset; synchronous, active-high.
AXI_AWADDR  in  ADDR_WIDTH  write address.
AXI_AWPROT  in  3  ignored.
AXI_AWVALID  in  1  write address valid.
AXI_AWREADY  out  1  write address ready.
AXI_WDATA  in  DATA_WIDTH  write data.
AXI_WSTRB  in  DATA_WIDTH/8  byte enables.
AXI_WVALID  in  1  write data valid.
AXI_WREADY  out  1  write data ready.
AXI_BRESP  out  2  2'b00 OKAY, 2'b10 SLVERR.
AXI_BVALID  out  1  write response valid.
AXI_BREADY  in  1  write response ready.
AXI_ARADDR  in  ADDR_WIDTH  read address.
AXI_ARPROT  in  3  ignored.
AXI_ARVALID  in  1  read address valid.
AXI_ARREADY  out  1  read address ready.
AXI_RDATA  out  DATA_WIDTH  read data.
AXI_RRESP  out  2  2'b00 OKAY, 2'b10 SLVERR.
AXI_RVALID  out  1  read data valid.
AXI_RREADY  in  1  read data ready.

Behaviour:
- Reset: while rst=1 on a clock edge, both FSMs go to IDLE; all READY/VALID outputs are 0; BRESP, RRESP and RDATA are 0. Array contents are not reset. After reset, AWREADY, WREADY and ARREADY are 1 in IDLE.
- Address decode:
  - off = addr - BASE_ADDR.
  - In range iff addr >= BASE_ADDR and off < (2^DEPTH_LOG2)*(DATA_WIDTH/8).
  - Word index = off[log2(DATA_WIDTH/8) +: DEPTH_LOG2]; low byte-offset bits are ignored (no alignment fault).
- Write FSM, states W_IDLE, W_COMMIT, W_RESP:
  - W_IDLE: AWREADY = !aw_held and WREADY = !w_held. AW and W handshakes are captured independently into holding registers, in either order or in the same cycle.
  - Once both are held, go to W_COMMIT and deassert both READYs.
  - W_COMMIT (1 cycle): if in range, write the bytes where WSTRB[i]=1 and set BRESP=OKAY. Otherwise leave the array untouched and set BRESP=SLVERR. Go to W_RESP.
  - W_RESP: BVALID=1, held stable until BVALID&&BREADY. Then clear the holding registers and return to W_IDLE.
  - WSTRB=0 is a valid no-op write and returns OKAY.
- Read FSM, states R_IDLE, R_WAIT, R_DATA:
  - R_IDLE: ARREADY=1. On handshake, latch the address and load the wait counter with RD_LATENCY. Go to R_WAIT, or straight to R_DATA if RD_LATENCY=0.
  - R_WAIT: ARREADY=0; decrement the counter; go to R_DATA when it reaches 1.
  - On entering R_DATA, sample RDATA from the array (or 0 if out of range) and set RRESP.
  - R_DATA: RVALID=1; RDATA and RRESP are held stable until RVALID&&RREADY, then return to R_IDLE. ARREADY stays 0 throughout.
  - Latency from the AR handshake edge to RVALID high is RD_LATENCY+1 cycles.
- Read and write channels run concurrently. If a W_COMMIT and the read sample hit the same word on the same edge, the read returns the pre-write data.
- Only one outstanding transaction per channel is allowed; no ID or burst support.
- A rst assertion mid-transaction aborts it immediately, with no response issued. A write is either fully committed in W_COMMIT or not at all.

Test Plan:
1. Write then read: AW 0x8000_0010 with W 0x1122334455667788, WSTRB 0xFF, BREADY=1 -> BVALID 2 cycles after the joint handshake with BRESP=00. AR 0x8000_0010, RD_LATENCY=1 -> RVALID 2 cycles after the AR handshake, RDATA 0x1122334455667788, RRESP=00.
2. Byte strobes: write 0xFFFF_FFFF_FFFF_FFFF to 0x8000_0010 with WSTRB 0x0F -> readback 0x11223344FFFFFFFF.
3. Channel ordering: W presented 3 cycles before AW -> WREADY drops after the W handshake; the write commits only after AW arrives; single BVALID.
4. Backpressure: BREADY=0 for 5 cycles and RREADY=0 for 5 cycles -> BVALID/BRESP and RVALID/RDATA held stable; AWREADY, WREADY and ARREADY stay 0 until the responses are accepted.
5. Out of range: AR 0x7FFF_FFF8 and AW/W to BASE_ADDR + 2^DEPTH_LOG2*8 -> RRESP=10 with RDATA 0 and BRESP=10; word 0 is unchanged on readback.
6. Reset mid-read: assert rst in R_WAIT -> next cycle RVALID=0 and ARREADY=0; after release ARREADY=1 and no stale RVALID appears.
